// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap stage: 256 iterations of j += S[i] + key[i mod KEY_BYTES], swap(S[i], S[j])
// over a shared single-port synchronous RAM, six cycles per iteration, one-cycle fin_strobe at the end.
module ksa_swap_fsm #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    input  logic [7:0]             q,
    output logic                   busy,
    output logic                   fin_strobe
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_I,
        S_LATCH_I,
        S_READ_J,
        S_LATCH_J,
        S_WRITE_I,
        S_WRITE_J,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [8*KEY_BYTES-1:0]   r_key;
    logic [7:0]               r_i;
    logic [7:0]               r_j;
    logic [7:0]               r_si;
    logic [7:0]               r_sj;
    logic [KIDX_W-1:0]        r_kidx;
    logic [7:0]               w_key_byte;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_READ_I;
            S_READ_I:  w_next_state = S_LATCH_I;
            S_LATCH_I: w_next_state = S_READ_J;
            S_READ_J:  w_next_state = S_LATCH_J;
            S_LATCH_J: w_next_state = S_WRITE_I;
            S_WRITE_I: w_next_state = S_WRITE_J;
            S_WRITE_J: w_next_state = (r_i == 8'hFF) ? S_DONE : S_READ_I;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Byte 0 of the key sits in the most significant byte.
    always_comb begin
        w_key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (r_kidx == KIDX_W'(b)) begin
                w_key_byte = r_key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key  <= '0;
            r_i    <= 8'h00;
            r_j    <= 8'h00;
            r_si   <= 8'h00;
            r_sj   <= 8'h00;
            r_kidx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key  <= key;
                        r_i    <= 8'h00;
                        r_j    <= 8'h00;
                        r_kidx <= '0;
                    end
                end
                S_LATCH_I: begin
                    r_si <= q;
                    r_j  <= r_j + q + w_key_byte;
                end
                S_LATCH_J: begin
                    r_sj <= q;
                end
                S_WRITE_J: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == KIDX_LAST) ? '0 : r_kidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reads and writes never share a cycle, so the RAM needs no read-during-write behaviour.
    always_comb begin
        address    = 8'h00;
        data       = 8'h00;
        wren       = 1'b0;
        busy       = 1'b0;
        fin_strobe = 1'b0;
        case (r_state)
            S_READ_I, S_LATCH_I: begin
                address = r_i;
                busy    = 1'b1;
            end
            S_READ_J, S_LATCH_J: begin
                address = r_j;
                busy    = 1'b1;
            end
            S_WRITE_I: begin
                address = r_i;
                data    = r_sj;
                wren    = 1'b1;
                busy    = 1'b1;
            end
            S_WRITE_J: begin
                address = r_j;
                data    = r_si;
                wren    = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                fin_strobe = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
